// File: rtl/serializer_pkg.sv
// Shared types and helpers for the parallel-to-serial shifter.
package serializer_pkg;

    // Three-state control FSM; encoding is fixed so other blocks can decode it.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_e;

    // Bit-counter width for a W-bit word, never narrower than one bit.
    function automatic int cnt_width(input int w);
        int cw;
        cw = $clog2(w);
        return (cw < 1) ? 1 : cw;
    endfunction

endpackage

// File: rtl/bit_cnt.sv
// Bit counter for the serializer: synchronous clear wins over increment.
module bit_cnt #(
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] count
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: clear, step or hold.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc) begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter register, cleared asynchronously on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/reg_serializer.sv
// Parallel-load, LSB-first serializer with valid/ready output handshake.
module reg_serializer
    import serializer_pkg::*;
#(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] D,
    output logic         ready,
    output logic         sdata,
    output logic         svalid,
    input  logic         sready,
    output logic         done
);

    localparam int CW = cnt_width(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    state_e        state_q, state_d;
    logic [W-1:0]  sreg_q, sreg_d;
    logic [CW-1:0] count;
    logic          cnt_clr;
    logic          cnt_inc;

    bit_cnt #(.CW(CW)) u_bit_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .count (count)
    );

    // Next-state, shift-register and counter control; load is only seen in IDLE.
    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (load) begin
                    sreg_d  = D;
                    cnt_clr = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (sready) begin
                    sreg_d = sreg_q >> 1;
                    if (count == LAST) begin
                        // Last bit leaves: park the counter at zero instead of wrapping.
                        cnt_clr = 1'b1;
                        state_d = DONE;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and shift register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            sreg_q  <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
        end
    end

    // Outputs decode from registered state only, so none is combinational from inputs.
    assign ready  = (state_q == IDLE);
    assign svalid = (state_q == SHIFT);
    assign done   = (state_q == DONE);
    assign sdata  = sreg_q[0];

endmodule

// File: tb/tb_reg_serializer.sv
// Directed bench for reg_serializer (W=5) with a serial-bit scoreboard.
module tb_reg_serializer;

    localparam int W = 5;

    logic         clk = 1'b0;
    logic         rst;
    logic         load;
    logic [W-1:0] D;
    logic         ready;
    logic         sdata;
    logic         svalid;
    logic         sready;
    logic         done;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int done_cnt = 0;
    int done_cyc[$];
    logic exp_q[$];

    reg_serializer #(.W(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .D      (D),
        .ready  (ready),
        .sdata  (sdata),
        .svalid (svalid),
        .sready (sready),
        .done   (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [W-1:0] w);
        for (int i = 0; i < W; i++) exp_q.push_back(w[i]);
    endtask

    // Advance to the next rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Count cycles until done is seen, bounded.
    task automatic wait_done(output int n);
        n = 0;
        for (int k = 0; k < 30; k++) begin
            step();
            n++;
            if (done) return;
        end
        check("done_timeout", 32'd0, 32'd1);
    endtask

    // Scoreboard monitor: mid-cycle, compare each handshaked bit and log done pulses.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (svalid && sready) begin
                check("bit_expected", (exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) check("bit_value", sdata, exp_q.pop_front());
            end
            if (done) begin
                done_cnt++;
                done_cyc.push_back(cyc);
                check("done_svalid", svalid, 1'b0);
                check("done_ready", ready, 1'b0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base;
        rst = 1'b0; load = 1'b0; D = '0; sready = 1'b0;
        #1;
        check("rst_ready", ready, 1'b1);
        check("rst_svalid", svalid, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_sdata", sdata, 1'b0);
        step(); step();
        rst = 1'b1;
        step();

        // Scenario 1: basic word, sready=1.
        load = 1'b1; D = 5'b11001; sready = 1'b1; push_word(5'b11001);
        step();
        load = 1'b0; D = '0;
        check("s1_svalid_latency", svalid, 1'b1);
        check("s1_first_bit", sdata, 1'b1);
        check("s1_ready_low", ready, 1'b0);
        wait_done(n);
        check("s1_done_cycles", n, 5);
        step();
        check("s1_done_pulse", done, 1'b0);
        check("s1_ready_back", ready, 1'b1);
        check("s1_q_empty", exp_q.size(), 0);

        // Scenario 2: backpressure on bit 2.
        load = 1'b1; D = 5'b11001; push_word(5'b11001);
        step();
        load = 1'b0;
        step();                      // bit 1 accepted
        sready = 1'b0;
        n = 1;
        for (int k = 0; k < 3; k++) begin
            step();
            n++;
            check("s2_hold_sdata", sdata, 1'b0);
            check("s2_hold_svalid", svalid, 1'b1);
        end
        sready = 1'b1;
        begin
            int m;
            wait_done(m);
            n += m;
        end
        check("s2_word_cycles", n, 8);
        step();
        check("s2_q_empty", exp_q.size(), 0);

        // Scenario 3: load during shift is ignored.
        load = 1'b1; D = 5'b11001; push_word(5'b11001);
        step();
        D = 5'b11111;
        step(); step();
        load = 1'b0;
        wait_done(n);
        check("s3_done_cycles", n, 3);
        step();
        check("s3_idle_ready", ready, 1'b1);
        check("s3_idle_svalid", svalid, 1'b0);
        check("s3_q_empty", exp_q.size(), 0);

        // Scenario 4: reset after two bits, then a zero word.
        load = 1'b1; D = 5'b11001; push_word(5'b11001);
        step();
        load = 1'b0;
        step(); step();              // two bits accepted
        base = done_cnt;
        #3;
        rst = 1'b0;
        #1;
        check("s4_rst_svalid", svalid, 1'b0);
        check("s4_rst_ready", ready, 1'b1);
        check("s4_rst_done", done, 1'b0);
        exp_q.delete();
        step(); step();
        check("s4_no_done", done_cnt, base);
        rst = 1'b1;
        load = 1'b1; D = 5'b00000; push_word(5'b00000);
        step();
        load = 1'b0;
        check("s4_zero_svalid", svalid, 1'b1);
        wait_done(n);
        check("s4_done_cycles", n, 5);
        step();
        check("s4_done_count", done_cnt, base + 1);
        check("s4_q_empty", exp_q.size(), 0);

        // Scenario 5: load held high, three back-to-back words.
        base = done_cnt;
        done_cyc.delete();
        load = 1'b1; D = 5'b10101;
        for (int k = 0; k < 3; k++) push_word(5'b10101);
        for (int k = 0; k < 3; k++) begin
            wait_done(n);
        end
        load = 1'b0;
        step(); step(); step();
        check("s5_done_count", done_cnt, base + 3);
        if (done_cyc.size() == 3) begin
            check("s5_period_a", done_cyc[1] - done_cyc[0], 7);
            check("s5_period_b", done_cyc[2] - done_cyc[1], 7);
        end else begin
            check("s5_done_log", done_cyc.size(), 3);
        end
        check("s5_q_empty", exp_q.size(), 0);
        check("s5_idle_ready", ready, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
